// File: rtl/memory_access_arbiter.sv
`default_nettype none
// ============================================================================
// memory_access_arbiter : round-robin sharing of a 4 x 8-bit byte store
// between two requesters, sequencing writes as SETUP/STORE/HOLD pulses.
// Revision 1.0
// ============================================================================
module memory_access_arbiter #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 2,
  parameter int HOLD_CYCLES = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req0_valid_i,
  input  logic              req0_write_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_wdata_i,
  output logic              req0_ready_o,
  output logic              req0_rvalid_o,
  output logic [DATA_W-1:0] req0_rdata_o,
  input  logic              req1_valid_i,
  input  logic              req1_write_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_wdata_i,
  output logic              req1_ready_o,
  output logic              req1_rvalid_o,
  output logic [DATA_W-1:0] req1_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_store_o,
  input  logic [DATA_W-1:0] mem_q_i,
  output logic              busy_o,
  output logic [7:0]        wr_count_o
);

  localparam int HOLD_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_STORE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;

  logic [2:0]        state_q,     state_d;
  logic              rr_ptr_q,    rr_ptr_d;
  logic              port_q,      port_d;
  logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_data_q,  mem_data_d;
  logic              mem_store_q, mem_store_d;
  logic [DATA_W-1:0] rdata0_q,    rdata0_d;
  logic [DATA_W-1:0] rdata1_q,    rdata1_d;
  logic              rvalid0_q,   rvalid0_d;
  logic              rvalid1_q,   rvalid1_d;
  logic [7:0]        wr_count_q,  wr_count_d;

  logic w_idle;
  logic w_gnt0;
  logic w_gnt1;

  // A lone requester always wins; on contention the pointer decides.
  assign w_idle = (state_q == S_IDLE);
  assign w_gnt0 = req0_valid_i & (~req1_valid_i | ~rr_ptr_q);
  assign w_gnt1 = req1_valid_i & (~req0_valid_i |  rr_ptr_q);

  assign req0_ready_o  = w_idle & w_gnt0;
  assign req1_ready_o  = w_idle & w_gnt1;
  assign req0_rvalid_o = rvalid0_q;
  assign req1_rvalid_o = rvalid1_q;
  assign req0_rdata_o  = rdata0_q;
  assign req1_rdata_o  = rdata1_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_data_o    = mem_data_q;
  assign mem_store_o   = mem_store_q;
  assign busy_o        = ~w_idle;
  assign wr_count_o    = wr_count_q;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    port_d      = port_q;
    hold_cnt_d  = hold_cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_store_d = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    wr_count_d  = wr_count_q;

    case (state_q)
      S_IDLE: begin
        if (w_gnt0 || w_gnt1) begin
          port_d     = w_gnt1;
          rr_ptr_d   = ~w_gnt1;
          mem_addr_d = w_gnt1 ? req1_addr_i : req0_addr_i;
          if (w_gnt1 ? req1_write_i : req0_write_i) begin
            mem_data_d = w_gnt1 ? req1_wdata_i : req0_wdata_i;
            state_d    = S_SETUP;
          end else begin
            state_d    = S_READ;
          end
        end
      end
      S_SETUP: begin
        mem_store_d = 1'b1;
        state_d     = S_STORE;
      end
      S_STORE: begin
        wr_count_d = wr_count_q + 8'd1;
        hold_cnt_d = HOLD_LOAD;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (hold_cnt_q <= HOLD_LAST) begin
          state_d = S_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_LAST;
        end
      end
      S_READ: begin
        if (port_q) begin
          rdata1_d  = mem_q_i;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = mem_q_i;
          rvalid0_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= 1'b0;
      port_q      <= 1'b0;
      hold_cnt_q  <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_store_q <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      wr_count_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      port_q      <= port_d;
      hold_cnt_q  <= hold_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_store_q <= mem_store_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      wr_count_q  <= wr_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_access_arbiter.sv
`default_nettype none
// tb_memory_access_arbiter : directed stimulus with a queue-based scoreboard
// for store pulses and read returns.
module tb_memory_access_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req0_write = 1'b0;
  logic [1:0] req0_addr = '0;
  logic [7:0] req0_wdata = '0;
  logic       req0_ready, req0_rvalid;
  logic [7:0] req0_rdata;
  logic       req1_valid = 1'b0, req1_write = 1'b0;
  logic [1:0] req1_addr = '0;
  logic [7:0] req1_wdata = '0;
  logic       req1_ready, req1_rvalid;
  logic [7:0] req1_rdata;
  logic [1:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_store;
  logic [7:0] mem_q;
  logic       busy;
  logic [7:0] wr_count;

  memory_access_arbiter #(.DATA_W(8), .ADDR_W(2), .HOLD_CYCLES(1)) dut (
    .clk_i(clk), .reset_i(reset),
    .req0_valid_i(req0_valid), .req0_write_i(req0_write), .req0_addr_i(req0_addr),
    .req0_wdata_i(req0_wdata), .req0_ready_o(req0_ready), .req0_rvalid_o(req0_rvalid),
    .req0_rdata_o(req0_rdata),
    .req1_valid_i(req1_valid), .req1_write_i(req1_write), .req1_addr_i(req1_addr),
    .req1_wdata_i(req1_wdata), .req1_ready_o(req1_ready), .req1_rvalid_o(req1_rvalid),
    .req1_rdata_o(req1_rdata),
    .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_store_o(mem_store),
    .mem_q_i(mem_q), .busy_o(busy), .wr_count_o(wr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte store model: latches data while store is high.
  logic [7:0] mem [4];
  always @(posedge clk) if (mem_store) mem[mem_addr] <= mem_data;
  assign mem_q = mem[mem_addr];

  int         n_cmp = 0;
  int         n_err = 0;
  logic [9:0] wq[$];
  logic [8:0] rq[$];
  logic [7:0] shadow [4];
  logic [9:0] wexp;
  logic [8:0] rexp;
  logic       store_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a store or read return.
  always @(negedge clk) begin
    if (reset) begin
      store_prev <= 1'b0;
    end else begin
      if (mem_store) begin
        check("store_repeat", 32'(store_prev), 32'd0);
        if (wq.size() == 0) check("store_unexpected", 32'd1, 32'd0);
        else begin
          wexp = wq.pop_front();
          check("store_addr_data", 32'({mem_addr, mem_data}), 32'(wexp));
        end
      end
      if (req0_rvalid) begin
        if (rq.size() == 0) check("rvalid0_unexpected", 32'd1, 32'd0);
        else begin
          rexp = rq.pop_front();
          check("read_p0", 32'({1'b0, req0_rdata}), 32'(rexp));
        end
      end
      if (req1_rvalid) begin
        if (rq.size() == 0) check("rvalid1_unexpected", 32'd1, 32'd0);
        else begin
          rexp = rq.pop_front();
          check("read_p1", 32'({1'b1, req1_rdata}), 32'(rexp));
        end
      end
      if (busy) check("ready_while_busy", 32'({req0_ready, req1_ready}), 32'd0);
      store_prev <= mem_store;
    end
  end

  function automatic logic rdy(input int p);
    return (p == 0) ? req0_ready : req1_ready;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int p, input logic w, input logic [1:0] a, input logic [7:0] d,
                       input logic push, output int acc);
    logic ok;
    if (push) begin
      if (w) begin
        wq.push_back({a, d});
        shadow[a] = d;
      end else begin
        rq.push_back({p[0], shadow[a]});
      end
    end
    if (p == 0) begin
      req0_valid = 1'b1; req0_write = w; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = 1'b1; req1_write = w; req1_addr = a; req1_wdata = d;
    end
    ok = 1'b0;
    acc = -1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (rdy(p)) begin
        ok = 1'b1;
        acc = cyc;
        break;
      end
    end
    if (!ok) check("ready_timeout", 32'd0, 32'd1);
    sync();
    if (p == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_reset();
    sync();
    reset = 1'b1;
    sync();
    reset = 1'b0;
  endtask

  initial begin
    int c0, acc, a0, a1, a2, a3;
    int racc [4];

    // Reset held two cycles with no requests.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_store", 32'(mem_store), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    check("rst_rdata", 32'({req0_rdata, req1_rdata}), 32'd0);
    sync();
    reset = 1'b0;
    sync();

    // Single write with cycle-exact timing.
    c0 = cyc;
    issue(0, 1'b1, 2'd2, 8'hA5, 1'b1, acc);
    check("w_ready_at_N", 32'(acc - c0), 32'd0);
    @(negedge clk);
    check("w_setup_addr", 32'(mem_addr), 32'd2);
    check("w_setup_data", 32'(mem_data), 32'hA5);
    check("w_setup_store", 32'(mem_store), 32'd0);
    check("w_setup_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("w_store_pulse", 32'(mem_store), 32'd1);
    @(negedge clk);
    check("w_hold_store", 32'(mem_store), 32'd0);
    check("w_hold_addr_data", 32'({mem_addr, mem_data}), 32'({2'd2, 8'hA5}));
    @(negedge clk);
    check("w_busy_N4", 32'(busy), 32'd0);
    check("w_wr_count", 32'(wr_count), 32'd1);
    sync();

    // Fill all locations, then read back addr 3 on port 1.
    issue(0, 1'b1, 2'd0, 8'h11, 1'b1, acc);
    issue(0, 1'b1, 2'd1, 8'h22, 1'b1, acc);
    issue(0, 1'b1, 2'd2, 8'h33, 1'b1, acc);
    issue(0, 1'b1, 2'd3, 8'h44, 1'b1, acc);
    wait_idle();
    sync();
    issue(1, 1'b0, 2'd3, 8'h00, 1'b1, acc);
    @(negedge clk);
    check("rd_rvalid_N1", 32'(req1_rvalid), 32'd0);
    @(negedge clk);
    check("rd_rvalid_N2", 32'(req1_rvalid), 32'd1);
    check("rd_rdata", 32'(req1_rdata), 32'h44);
    check("rd_other_rvalid", 32'(req0_rvalid), 32'd0);
    @(negedge clk);
    check("rd_rvalid_N3", 32'(req1_rvalid), 32'd0);
    check("rd_rdata_hold", 32'(req1_rdata), 32'h44);
    check("rd_other_rdata", 32'(req0_rdata), 32'h00);
    check("rd_wr_count", 32'(wr_count), 32'd5);

    // Contention: grants must go 0,1,0,1 after reset.
    pulse_reset();
    wq.push_back({2'd0, 8'h50}); shadow[0] = 8'h50;
    wq.push_back({2'd2, 8'h60}); shadow[2] = 8'h60;
    wq.push_back({2'd1, 8'h51}); shadow[1] = 8'h51;
    wq.push_back({2'd3, 8'h61}); shadow[3] = 8'h61;
    fork
      begin
        issue(0, 1'b1, 2'd0, 8'h50, 1'b0, a0);
        issue(0, 1'b1, 2'd1, 8'h51, 1'b0, a2);
      end
      begin
        issue(1, 1'b1, 2'd2, 8'h60, 1'b0, a1);
        issue(1, 1'b1, 2'd3, 8'h61, 1'b0, a3);
      end
    join
    check("cont_order", 32'({a0 < a1, a1 < a2, a2 < a3}), 32'b111);
    wait_idle();
    check("cont_wr_count", 32'(wr_count), 32'd4);

    // Reset landing on the STORE cycle.
    sync();
    issue(0, 1'b1, 2'd1, 8'h77, 1'b1, acc);
    @(negedge clk);
    @(negedge clk);
    check("mid_store_high", 32'(mem_store), 32'd1);
    #1 reset = 1'b1;
    @(negedge clk);
    check("mid_store_low", 32'(mem_store), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_wr_count", 32'(wr_count), 32'd0);
    check("mid_rvalid", 32'({req0_rvalid, req1_rvalid}), 32'd0);
    sync();
    reset = 1'b0;
    wq.push_back({2'd2, 8'h12}); shadow[2] = 8'h12;
    wq.push_back({2'd3, 8'h13}); shadow[3] = 8'h13;
    fork
      issue(0, 1'b1, 2'd2, 8'h12, 1'b0, a0);
      issue(1, 1'b1, 2'd3, 8'h13, 1'b0, a1);
      begin
        @(negedge clk);
        check("mid_rr_ptr0", 32'({req0_ready, req1_ready}), 32'b10);
      end
    join
    wait_idle();

    // 256 writes wrap the counter; then back-to-back reads.
    pulse_reset();
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        wait_idle();
        check("wrap_255", 32'(wr_count), 32'd255);
        sync();
      end
      issue(0, 1'b1, 2'(i % 4), 8'(i), 1'b1, acc);
    end
    wait_idle();
    check("wrap_zero", 32'(wr_count), 32'd0);
    sync();
    for (int j = 0; j < 4; j++) issue(1, 1'b0, 2'(j), 8'h00, 1'b1, racc[j]);
    for (int j = 1; j < 4; j++) check("b2b_spacing", 32'(racc[j] - racc[j-1]), 32'd2);
    wait_idle();
    repeat (3) @(negedge clk);
    check("b2b_last_rdata", 32'(req1_rdata), 32'hFF);
    check("wq_drained", 32'(wq.size()), 32'd0);
    check("rq_drained", 32'(rq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
